// File: rtl/quicksort_ctrl.sv
// Quicksort initiator: owns the (lo, hi) range stack and drives a Lomuto partition engine one range at a time.
// Latency: data-dependent; 2 cycles from accepted sort_start to the first part_start, done one cycle after the stack empties.
// Backpressure: none; one request in flight, result taken on the part_ready pulse, watchdog aborts a silent engine.
module quicksort_ctrl #(
    parameter int N           = 4,
    parameter int DATA_W      = 4,
    parameter int IDX_W       = 2,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sort_start,
    input  logic [N*DATA_W-1:0] array_in,
    output logic                sort_busy,
    output logic                sort_done,
    output logic                sort_err,
    output logic [N*DATA_W-1:0] array_out,
    output logic                part_start,
    output logic [IDX_W-1:0]    part_lo,
    output logic [IDX_W-1:0]    part_hi,
    output logic [N*DATA_W-1:0] part_array,
    input  logic                part_ready,
    input  logic [N*DATA_W-1:0] part_array_res,
    input  logic [IDX_W-1:0]    part_pivot_idx
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [SP_W-1:0]     sp;
    logic [WD_W-1:0]     wd;
    logic [N*DATA_W-1:0] work;
    logic [IDX_W-1:0]    pivot;
    logic [IDX_W-1:0]    stk_lo [STACK_DEPTH];
    logic [IDX_W-1:0]    stk_hi [STACK_DEPTH];

    logic [SI_W-1:0]     top_idx, push_idx, push_idx2;
    logic [IDX_W-1:0]    top_lo, top_hi;
    logic                push_r, push_l, pivot_bad, overflow;
    logic [SP_W:0]       sp_after;
    logic                accept, pop, launch, take_res, push_ok, fail, finish;

    assign top_idx   = SI_W'(sp - SP_W'(1));
    assign top_lo    = stk_lo[top_idx];
    assign top_hi    = stk_hi[top_idx];
    assign pivot_bad = (part_pivot_idx < part_lo) || (part_pivot_idx > part_hi);

    // Right range goes in first so the left range ends up on top.
    assign push_r    = pivot < part_hi;
    assign push_l    = pivot > part_lo;
    assign push_idx  = SI_W'(sp);
    assign push_idx2 = push_r ? SI_W'(sp + SP_W'(1)) : SI_W'(sp);
    assign sp_after  = {1'b0, sp} + {{SP_W{1'b0}}, push_r} + {{SP_W{1'b0}}, push_l};
    assign overflow  = sp_after > (SP_W + 1)'(STACK_DEPTH);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pop       = 1'b0;
        launch    = 1'b0;
        take_res  = 1'b0;
        push_ok   = 1'b0;
        fail      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sort_start) begin
                    accept    = 1'b1;
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                if (sp == '0) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    pop = 1'b1;
                    if (top_lo < top_hi) begin
                        launch    = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (part_ready) begin
                    if (pivot_bad) begin
                        fail      = 1'b1;
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        take_res  = 1'b1;
                        state_nxt = S_PUSH;
                    end
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_PUSH: begin
                if (overflow) begin
                    fail      = 1'b1;
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    push_ok   = 1'b1;
                    state_nxt = S_POP;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            sp         <= '0;
            wd         <= '0;
            work       <= '0;
            pivot      <= '0;
            sort_busy  <= 1'b0;
            sort_done  <= 1'b0;
            sort_err   <= 1'b0;
            array_out  <= '0;
            part_start <= 1'b0;
            part_lo    <= '0;
            part_hi    <= '0;
            part_array <= '0;
        end else begin
            state      <= state_nxt;
            part_start <= launch;
            sort_done  <= finish;
            if (accept) begin
                work      <= array_in;
                sort_err  <= 1'b0;
                sort_busy <= 1'b1;
                sp        <= SP_W'(1);
            end
            if (pop) begin
                sp <= sp - SP_W'(1);
            end
            if (launch) begin
                part_lo    <= top_lo;
                part_hi    <= top_hi;
                part_array <= work;
            end
            if (state == S_ISSUE) begin
                wd <= '0;
            end else if (state == S_WAIT) begin
                wd <= wd + WD_W'(1);
            end
            if (take_res) begin
                work  <= part_array_res;
                pivot <= part_pivot_idx;
            end
            if (push_ok) begin
                sp <= sp_after[SP_W-1:0];
            end
            if (fail) begin
                sort_err <= 1'b1;
            end
            if (finish) begin
                array_out <= work;
                sort_busy <= 1'b0;
            end
        end
    end

    // Stack storage needs no reset: the accept write always seeds entry 0.
    always_ff @(posedge clock) begin
        if (accept) begin
            stk_lo[0] <= '0;
            stk_hi[0] <= IDX_W'(N - 1);
        end
        if (push_ok && push_r) begin
            stk_lo[push_idx] <= pivot + IDX_W'(1);
            stk_hi[push_idx] <= part_hi;
        end
        if (push_ok && push_l) begin
            stk_lo[push_idx2] <= part_lo;
            stk_hi[push_idx2] <= pivot - IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_quicksort_ctrl.sv
// Bench for quicksort_ctrl: a cycle-stepped Lomuto engine model answers requests, results are checked
// against a plain queue sort of the input elements.
module tb_quicksort_ctrl;
    localparam int IW = 2;
    localparam int W  = 16;
    localparam int M_NORMAL  = 0;
    localparam int M_BADPIV  = 1;
    localparam int M_NOREADY = 2;

    logic          clock = 1'b0;
    logic          reset, sort_start, part_ready;
    logic [W-1:0]  array_in, part_array_res;
    logic [IW-1:0] part_pivot_idx;
    logic          sort_busy, sort_done, sort_err, part_start;
    logic [W-1:0]  array_out, part_array;
    logic [IW-1:0] part_lo, part_hi;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] obs_arr;
    logic         obs_done, obs_err, obs_err_first, obs_busy_at_done, obs_done_after;
    int           obs_first_start, obs_done_cyc, obs_starts, obs_unstable, obs_busy_bad;
    int           obs_first_lo, obs_first_hi;
    int           obs_pivots[$];

    quicksort_ctrl #(
        .N(4), .DATA_W(4), .IDX_W(2), .STACK_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .sort_start(sort_start), .array_in(array_in),
        .sort_busy(sort_busy), .sort_done(sort_done), .sort_err(sort_err), .array_out(array_out),
        .part_start(part_start), .part_lo(part_lo), .part_hi(part_hi), .part_array(part_array),
        .part_ready(part_ready), .part_array_res(part_array_res), .part_pivot_idx(part_pivot_idx)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_sort(input logic [W-1:0] a);
        int q[$];
        logic [W-1:0] r;
        for (int k = 0; k < 4; k++) q.push_back(int'(a[k*4 +: 4]));
        q.sort();
        r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(q[k]);
        return r;
    endfunction

    function automatic void lomuto(input logic [W-1:0] a, input int lo, input int hi,
                                   output logic [W-1:0] r, output int p);
        int e[4];
        int pv, i, t;
        for (int k = 0; k < 4; k++) e[k] = int'(a[k*4 +: 4]);
        pv = e[hi];
        i  = lo;
        for (int j = lo; j < hi; j++) begin
            if (e[j] < pv) begin
                t = e[i]; e[i] = e[j]; e[j] = t;
                i++;
            end
        end
        t = e[i]; e[i] = e[hi]; e[hi] = t;
        p = i;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(e[k]);
    endfunction

    // Runs one sort with the engine model answering after 3 cycles; records observations only.
    task automatic run_sort(input logic [W-1:0] arr, input int mode, input bit hold);
        logic [W-1:0] req_arr, res;
        int rlo, rhi, p, cnt, cyc;
        bit pending;
        obs_starts = 0; obs_unstable = 0; obs_busy_bad = 0;
        obs_first_start = -1; obs_first_lo = -1; obs_first_hi = -1;
        obs_pivots.delete();
        req_arr = '0; res = '0; rlo = 0; rhi = 0; p = 0; cnt = 0;
        array_in   = arr;
        sort_start = 1'b1;
        part_ready = 1'b0;
        @(posedge clock); #1;
        cyc = 1;
        obs_err_first = sort_err;
        if (!hold) sort_start = 1'b0;
        array_in = ~arr;
        pending  = 1'b0;
        while (!sort_done && cyc < 400) begin
            part_ready = 1'b0;
            if (!sort_busy) obs_busy_bad++;
            if (part_start) begin
                obs_starts++;
                if (obs_first_start < 0) begin
                    obs_first_start = cyc;
                    obs_first_lo    = int'(part_lo);
                    obs_first_hi    = int'(part_hi);
                end
                req_arr = part_array;
                rlo     = int'(part_lo);
                rhi     = int'(part_hi);
                lomuto(req_arr, rlo, rhi, res, p);
                if (mode == M_BADPIV && rlo == 0 && rhi == 1) p = 3;
                obs_pivots.push_back(p);
                pending = 1'b1;
                cnt     = 3;
            end else if (pending) begin
                if (part_lo !== IW'(rlo) || part_hi !== IW'(rhi) || part_array !== req_arr)
                    obs_unstable++;
                if (mode != M_NOREADY) begin
                    cnt--;
                    if (cnt == 0) begin
                        part_ready     = 1'b1;
                        part_array_res = res;
                        part_pivot_idx = IW'(p);
                        pending        = 1'b0;
                    end
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        part_ready       = 1'b0;
        sort_start       = 1'b0;
        obs_done         = sort_done;
        obs_done_cyc     = cyc;
        obs_err          = sort_err;
        obs_arr          = array_out;
        obs_busy_at_done = sort_busy;
        @(posedge clock); #1;
        obs_done_after = sort_done;
    endtask

    task automatic test_reset();
        bit found, done_seen;
        int bad;
        reset = 1'b1; sort_start = 1'b0; part_ready = 1'b0;
        array_in = '0; part_array_res = '0; part_pivot_idx = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({sort_busy, sort_done, sort_err, part_start, part_lo, part_hi, array_out, part_array} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b ps=%b out=%h exp all zero",
                     sort_busy, sort_done, sort_err, part_start, array_out);
        end
        reset = 1'b0;
        array_in = 16'h0213; sort_start = 1'b1;
        @(posedge clock); #1;
        sort_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (part_start) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_start got no part_start exp part_start within 20 cycles");
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            if (sort_done) done_seen = 1'b1;
            checks++;
            if ({sort_busy, sort_done, sort_err, part_start, part_lo, part_hi, array_out, part_array} !== '0) begin
                errors++;
                $display("FAIL reset_mid_wait cycle %0d got busy=%b ps=%b lo=%0d hi=%0d arr=%h exp all zero",
                         i, sort_busy, part_start, part_lo, part_hi, part_array);
            end
        end
        reset = 1'b0;
        @(posedge clock); #1;
        part_ready = 1'b1; part_array_res = 16'hFFFF; part_pivot_idx = 2'd1;
        @(posedge clock); #1;
        part_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (sort_busy || sort_done || part_start || array_out !== '0) bad++;
            if (sort_done) done_seen = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_stray_ready got %0d active cycles exp 0", bad);
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got done=%b exp 0", done_seen);
        end
    endtask

    task automatic test_basic_sort();
        run_sort(16'h0213, M_NORMAL, 1'b0);
        checks++;
        if (obs_first_start !== 2) begin
            errors++; $display("FAIL basic_first_start got cycle %0d exp 2", obs_first_start);
        end
        checks++;
        if (obs_first_lo !== 0 || obs_first_hi !== 3) begin
            errors++; $display("FAIL basic_first_range got (%0d,%0d) exp (0,3)", obs_first_lo, obs_first_hi);
        end
        checks++;
        if (obs_done !== 1'b1 || obs_arr !== 16'h3210) begin
            errors++; $display("FAIL basic_result got done=%b arr=%h exp done=1 arr=3210", obs_done, obs_arr);
        end
        checks++;
        if (obs_err !== 1'b0 || obs_busy_at_done !== 1'b0 || obs_done_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags got err=%b busy=%b done_next=%b exp 0 0 0",
                     obs_err, obs_busy_at_done, obs_done_after);
        end
        checks++;
        if (obs_busy_bad !== 0 || obs_unstable !== 0) begin
            errors++;
            $display("FAIL basic_protocol got busy_low=%0d unstable=%0d exp 0 0", obs_busy_bad, obs_unstable);
        end
    endtask

    task automatic test_already_sorted();
        run_sort(16'h3210, M_NORMAL, 1'b0);
        checks++;
        if (obs_starts !== 3) begin
            errors++; $display("FAIL sorted_starts got %0d exp 3", obs_starts);
        end
        checks++;
        if (obs_pivots.size() !== 3 || obs_pivots[0] !== 3 || obs_pivots[1] !== 2 || obs_pivots[2] !== 1) begin
            errors++; $display("FAIL sorted_pivots got %0d pivots exp 3,2,1", obs_pivots.size());
        end
        checks++;
        if (obs_arr !== 16'h3210 || obs_err !== 1'b0) begin
            errors++; $display("FAIL sorted_result got arr=%h err=%b exp 3210 0", obs_arr, obs_err);
        end
    endtask

    task automatic test_bad_pivot();
        run_sort(16'h3201, M_BADPIV, 1'b0);
        checks++;
        if (obs_done !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL badpiv_err got done=%b err=%b exp 1 1", obs_done, obs_err);
        end
        checks++;
        if (obs_arr !== 16'h3201) begin
            errors++; $display("FAIL badpiv_array got %h exp 3201", obs_arr);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sort_err !== 1'b1) begin
            errors++; $display("FAIL badpiv_err_held got %b exp 1", sort_err);
        end
        run_sort(16'h1032, M_NORMAL, 1'b0);
        checks++;
        if (obs_err_first !== 1'b0 || obs_err !== 1'b0 || obs_arr !== 16'h3210) begin
            errors++;
            $display("FAIL badpiv_recover got err_at_accept=%b err=%b arr=%h exp 0 0 3210",
                     obs_err_first, obs_err, obs_arr);
        end
    endtask

    task automatic test_timeout();
        run_sort(16'h0213, M_NOREADY, 1'b0);
        checks++;
        if (obs_done !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL timeout_err got done=%b err=%b exp 1 1", obs_done, obs_err);
        end
        checks++;
        if (obs_done_cyc - (obs_first_start + 1) !== 16) begin
            errors++;
            $display("FAIL timeout_latency got %0d cycles exp 16", obs_done_cyc - (obs_first_start + 1));
        end
        checks++;
        if (obs_arr !== 16'h0213) begin
            errors++; $display("FAIL timeout_array got %h exp 0213", obs_arr);
        end
    endtask

    task automatic test_hold_start();
        logic [W-1:0] a;
        a = 16'(($urandom & 32'hFFFF));
        run_sort(a, M_NORMAL, 1'b1);
        checks++;
        if (obs_done !== 1'b1 || obs_arr !== ref_sort(a) || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_result in=%h got arr=%h err=%b exp arr=%h err=0", a, obs_arr, obs_err, ref_sort(a));
        end
        checks++;
        if (obs_unstable !== 0 || obs_busy_bad !== 0 || obs_done_after !== 1'b0) begin
            errors++;
            $display("FAIL hold_protocol got unstable=%0d busy_low=%0d done_next=%b exp 0 0 0",
                     obs_unstable, obs_busy_bad, obs_done_after);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        for (int n = 0; n < 20; n++) begin
            a = 16'(($urandom & 32'hFFFF));
            run_sort(a, M_NORMAL, 1'b0);
            checks++;
            if (obs_done !== 1'b1 || obs_arr !== ref_sort(a)) begin
                errors++;
                $display("FAIL b2b_result[%0d] in=%h got done=%b arr=%h exp arr=%h", n, a, obs_done, obs_arr, ref_sort(a));
            end
            checks++;
            if (obs_err !== 1'b0 || obs_first_start !== 2) begin
                errors++;
                $display("FAIL b2b_flags[%0d] got err=%b first_start=%0d exp 0 2", n, obs_err, obs_first_start);
            end
            checks++;
            if (obs_unstable !== 0 || obs_busy_bad !== 0 || obs_done_after !== 1'b0) begin
                errors++;
                $display("FAIL b2b_protocol[%0d] got unstable=%0d busy_low=%0d done_next=%b exp 0 0 0",
                         n, obs_unstable, obs_busy_bad, obs_done_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sort();
        test_already_sorted();
        test_bad_pivot();
        test_timeout();
        test_hold_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/quicksort_ctrl.md
Name: quicksort_ctrl

Overview:
- Initiator side of the partition interface: owns the quicksort range stack and drives a Lomuto partition engine one sub-range at a time.
- Accepts an unsorted packed array from the host and issues partition requests (lo, hi, array).
- Consumes each result (rearranged array, final pivot index) and pushes the resulting sub-ranges.
- Returns the sorted array with a done pulse.

Parameters:
- N, 4, number of array elements.
- DATA_W, 4, element width in bits.
- IDX_W, 2, index width; must satisfy 2^IDX_W >= N.
- STACK_DEPTH, 4, range-stack entries, each a (lo, hi) pair.
- TIMEOUT, 16, maximum cycles in WAIT before the error abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sort_start  in  1  host request, sampled in IDLE only.
- array_in  in  N*DATA_W  unsorted array; element i at [i*DATA_W +: DATA_W].
- sort_busy  out  1  high from the cycle after sort_start is accepted until sort_done.
- sort_done  out  1  one-cycle completion pulse.
- sort_err  out  1  error flag, valid with sort_done, held until the next accepted sort_start.
- array_out  out  N*DATA_W  sorted result, same packing, held after done.
- part_start  out  1  one-cycle partition request.
- part_lo  out  IDX_W  range low index.
- part_hi  out  IDX_W  range high index; the pivot element is at hi.
- part_array  out  N*DATA_W  working array sent to the engine.
- part_ready  in  1  engine result valid, one-cycle pulse.
- part_array_res  in  N*DATA_W  partitioned array.
- part_pivot_idx  in  IDX_W  final pivot position.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, stack pointer 0, watchdog counter 0.
- Reset in any state, including mid-WAIT, returns to IDLE within one cycle with no done pulse. A part_ready arriving afterwards is ignored.
- States: IDLE, POP, ISSUE, WAIT, PUSH, DONE.
- IDLE:
  - sort_start=1: latch array_in into the working register, clear sort_err, push (0, N-1), go to POP. sort_busy=1 from the next cycle.
  - sort_start is ignored in every other state.
- POP:
  - Stack empty: go to DONE.
  - Otherwise pop the top entry. If lo >= hi, discard it and stay in POP, one entry per cycle. Else latch part_lo/part_hi and go to ISSUE.
- ISSUE:
  - part_start=1 for exactly this cycle; part_array = working register.
  - Go to WAIT and clear the watchdog.
- WAIT:
  - part_lo, part_hi and part_array are held stable.
  - The watchdog increments every cycle.
  - part_ready=1: copy part_array_res into the working register, latch p = part_pivot_idx, go to PUSH.
  - If p < part_lo or p > part_hi: set sort_err and go to DONE; the working register keeps the pre-request array.
  - Watchdog reaching TIMEOUT with no ready: set sort_err, go to DONE.
  - part_ready outside WAIT is ignored.
- PUSH:
  - Same cycle, in this order: push (p+1, hi) if p < hi, then push (lo, p-1) if p > lo. The left range sits on top and is processed first.
  - Either, both or neither push may occur.
  - If the required pushes exceed STACK_DEPTH: set sort_err, go to DONE, and write no partial push.
  - Otherwise go to POP.
  - Index arithmetic is IDX_W wide. p-1 and p+1 are guarded by the compares above, so they never wrap.
- DONE:
  - array_out = working register.
  - sort_done=1 and sort_busy=0 in this cycle.
  - Go to IDLE.
- N=1: the pushed range (0,0) is discarded in POP, no part_start is issued, and array_out = array_in.

Test Plan:
- Reset: assert reset 2 cycles mid-WAIT -> all outputs 0, no sort_done; a part_ready pulse one cycle later is ignored (state stays IDLE).
- Basic sort: array_in=16'h0213 (elements 3,1,2,0), behavioural Lomuto engine with 3-cycle latency -> first part_start exactly 2 cycles after sort_start is sampled, with part_lo=0, part_hi=3; final array_out=16'h3210, one sort_done pulse, sort_err=0.
- Already sorted: array_in=16'h3210 -> engine pivots 3, 2, 1 in order; array_out=16'h3210; exactly 3 part_start pulses.
- Bad pivot: engine returns part_pivot_idx=3 for a request with lo=0, hi=1 -> sort_err=1 with sort_done; array_out equals the array sent in that request.
- Timeout: engine never asserts part_ready, TIMEOUT=16 -> sort_done and sort_err exactly 16 cycles after entering WAIT.
- Protocol: sort_start held high through a whole sort -> exactly one sort accepted per IDLE visit; part_lo/part_hi/part_array constant throughout every WAIT.
